reg_ab_writeback: RTL and testbench
===================================

REG_AB_WRITEBACK -- requirements
Module: reg_ab_writeback

Interface
REQ-001 Parameter: WIDTH, 8, data width of operand registers A/B and result bus.
REQ-002 Parameter: DEPTH, 2, write-queue entries (power of two, at least 2).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: res_valid  input  1  ALU result offered for write-back.
REQ-006 Port: res_ready  output  1  queue can accept a result this cycle.
REQ-007 Port: res_data  input  WIDTH  ALU result value.
REQ-008 Port: res_c  input  1  ALU carry-out accompanying res_data.
REQ-009 Port: dst  input  2  destination: 00 none (flags only), 01 A, 10 B, 11 A and B.
REQ-010 Port: freeze  input  1  stalls draining of the queue; acceptance continues.
REQ-011 Port: A  output  WIDTH  operand register A, feeds the ALU operand mux.
REQ-012 Port: B  output  WIDTH  operand register B, feeds the ALU operand mux.
REQ-013 Port: flag_z, flag_n, flag_c  output  1 each  zero, negative, carry of last retired write.
REQ-014 Port: pend_cnt  output  clog2(DEPTH)+1  number of queued, unretired writes.

Function
REQ-015 Transfer occurs on a rising edge where res_valid and res_ready are both 1; the {res_data, res_c, dst} triple is pushed into the FIFO queue.
REQ-016 res_ready shall be 1 exactly when pend_cnt < DEPTH (registered count); a pop in the same cycle does not raise res_ready when the queue is full.
REQ-017 Each edge with freeze=0 and pend_cnt>0 shall pop the head entry and retire it: write res_data to A if dst[0], to B if dst[1]; set flag_z=(data==0), flag_n=data[WIDTH-1], flag_c=res_c.
REQ-018 dst=00 shall retire normally and update flags only; A and B unchanged.
REQ-019 Default latency: a result accepted at edge N with an empty queue and freeze=0 shall appear on A/B/flags after edge N+1.
REQ-020 Simultaneous push and pop shall leave pend_cnt unchanged and preserve FIFO order.
REQ-021 freeze=1 shall hold A, B, flags and queue contents; pushes still accepted while not full.
REQ-022 Read/write pointers shall wrap modulo DEPTH; pend_cnt shall never exceed DEPTH nor underflow.
REQ-023 res_data/res_c/dst shall be ignored when res_valid=0 or res_ready=0.

Reset
REQ-024 When rst_n=0 at a rising edge: A=0, B=0, flag_z=1, flag_n=0, flag_c=0, pend_cnt=0, pointers=0, res_ready=1 after that edge.
REQ-025 Reset mid-operation shall discard all queued writes; a handshake coinciding with reset shall be dropped.

Configuration
REQ-026 Macro WB_BYPASS_EN: when defined, a result accepted at edge N with pend_cnt=0 and freeze=0 shall retire at edge N itself (not enqueued, pend_cnt stays 0); otherwise REQ-019 timing applies.
REQ-027 Without WB_BYPASS_EN, every accepted result passes through the queue; bypass logic is absent.

Verification
REQ-028 Reset: rst_n=0 one edge -> A=0x00, B=0x00, flag_z=1, pend_cnt=0, res_ready=1.
REQ-029 Single write: res_data=0x80, res_c=1, dst=01 accepted at edge N -> after N+1 A=0x80, B unchanged, flag_n=1, flag_c=1, flag_z=0 (after N with WB_BYPASS_EN).
REQ-030 Fill: freeze=1, push 0x11 dst=10 then 0x22 dst=11 -> pend_cnt=2, res_ready=0, third offer not accepted; release freeze -> B=0x11 next edge, then A=B=0x22, pend_cnt=0.
REQ-031 Flags-only: res_data=0x00, dst=00 -> A/B unchanged, flag_z=1, flag_n=0.
REQ-032 Back-to-back: res_valid held 1 for 4 cycles with 0x01..0x04, dst=01, freeze=0 -> pend_cnt stays <=1, A sequence 0x01,0x02,0x03,0x04 in order.
REQ-033 Reset with pend_cnt=2 -> next cycle pend_cnt=0, A/B=0x00, no queued write retires afterwards.

Source files
------------

// File: rtl/reg_ab_writeback.sv
// rtl/reg_ab_writeback.sv - queued A/B operand register write-back with flags (optional WB_BYPASS_EN)
module reg_ab_writeback #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       res_valid,
    output logic                       res_ready,
    input  logic [WIDTH-1:0]           res_data,
    input  logic                       res_c,
    input  logic [1:0]                 dst,
    input  logic                       freeze,
    output logic [WIDTH-1:0]           A,
    output logic [WIDTH-1:0]           B,
    output logic                       flag_z,
    output logic                       flag_n,
    output logic                       flag_c,
    output logic [$clog2(DEPTH):0]     pend_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] q_data [DEPTH];
    logic             q_c    [DEPTH];
    logic [1:0]       q_dst  [DEPTH];

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;

    logic             push;
    logic             pop_q;
    logic             bypass;
    logic             enq;
    logic             retire;
    logic [WIDTH-1:0] ret_data;
    logic             ret_c;
    logic [1:0]       ret_dst;

    // Ready looks only at the registered count, so a full queue stalls even while draining.
    assign res_ready = (count < CW'(DEPTH));
    assign push      = res_valid && res_ready;
    assign pop_q     = !freeze && (count != '0);

`ifdef WB_BYPASS_EN
    assign bypass    = push && (count == '0) && !freeze;
`else
    assign bypass    = 1'b0;
`endif

    assign enq       = push && !bypass;
    assign retire    = pop_q || bypass;
    assign ret_data  = bypass ? res_data : q_data[rptr];
    assign ret_c     = bypass ? res_c    : q_c[rptr];
    assign ret_dst   = bypass ? dst      : q_dst[rptr];

    always_ff @(posedge clk) begin
        if (enq) begin
            q_data[wptr] <= res_data;
            q_c[wptr]    <= res_c;
            q_dst[wptr]  <= dst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq)   wptr <= wptr + 1'b1;
            if (pop_q) rptr <= rptr + 1'b1;
            case ({enq, pop_q})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            A      <= '0;
            B      <= '0;
            flag_z <= 1'b1;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
        end else if (retire) begin
            if (ret_dst[0]) A <= ret_data;
            if (ret_dst[1]) B <= ret_data;
            flag_z <= (ret_data == '0);
            flag_n <= ret_data[WIDTH-1];
            flag_c <= ret_c;
        end
    end

    assign pend_cnt = count;
endmodule

// File: tb/tb_reg_ab_writeback.sv
// tb/tb_reg_ab_writeback.sv - randomized bench for reg_ab_writeback against a queue-based reference model
module tb_reg_ab_writeback;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_c;
    logic [1:0]       dst;
    logic             freeze;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic [$clog2(DEPTH):0] pend_cnt;

    reg_ab_writeback #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_c(res_c), .dst(dst), .freeze(freeze),
        .A(A), .B(B), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int c;
        int t;
    } wb_t;

    wb_t q[$];
    int  m_a, m_b, m_z, m_n, m_c;
    int  checks = 0;
    int  errors = 0;
    bit  model_init = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void retire_item(input wb_t w);
        if (w.t % 2 == 1) m_a = w.d;
        if (w.t >= 2)     m_b = w.d;
        m_z = (w.d == 0) ? 1 : 0;
        m_n = (w.d >= 128) ? 1 : 0;
        m_c = w.c;
    endfunction

    // One clock: drive at negedge, check ready, clock, advance model, check state.
    task automatic cycle(input int v, input int d, input int c, input int t,
                         input int frz, input int rst);
        wb_t w;
        bit  acc;
        @(negedge clk);
        rst_n = rst[0]; res_valid = v[0]; res_data = d[WIDTH-1:0];
        res_c = c[0]; dst = t[1:0]; freeze = frz[0];
        #1;
        if (model_init) check("res_ready", int'(res_ready), (q.size() < DEPTH) ? 1 : 0);
        @(posedge clk);
        #1;
        if (rst == 0) begin
            q.delete();
            m_a = 0; m_b = 0; m_z = 1; m_n = 0; m_c = 0;
            model_init = 1;
        end else begin
            acc = (v != 0) && (q.size() < DEPTH);
            w.d = d; w.c = c; w.t = t;
`ifdef WB_BYPASS_EN
            if (acc && q.size() == 0 && frz == 0) begin
                retire_item(w);
                acc = 0;
            end else
`endif
            if (frz == 0 && q.size() > 0) retire_item(q.pop_front());
            if (acc) q.push_back(w);
        end
        if (model_init) begin
            check("A", int'(A), m_a);
            check("B", int'(B), m_b);
            check("flag_z", int'(flag_z), m_z);
            check("flag_n", int'(flag_n), m_n);
            check("flag_c", int'(flag_c), m_c);
            check("pend_cnt", int'(pend_cnt), q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; res_valid = 1'b0; res_data = '0; res_c = 1'b0; dst = 2'b00; freeze = 1'b0;

        cycle(0, 0, 0, 0, 0, 0);
        check("reset_A", int'(A), 0);
        check("reset_B", int'(B), 0);
        check("reset_z", int'(flag_z), 1);
        check("reset_ready", int'(res_ready), 1);

        // single write to A with negative and carry
        cycle(1, 8'h80, 1, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        check("single_A", int'(A), 8'h80);
        check("single_B", int'(B), 0);
        check("single_nc", int'({flag_z, flag_n, flag_c}), 3'b011);

        // fill under freeze, third offer refused, then drain in order
        cycle(1, 8'h11, 0, 2, 1, 1);
        cycle(1, 8'h22, 0, 3, 1, 1);
        check("fill_pend", int'(pend_cnt), 2);
        check("fill_ready", int'(res_ready), 0);
        cycle(1, 8'h33, 0, 3, 1, 1);
        cycle(0, 0, 0, 0, 0, 1);
        check("drain1_B", int'(B), 8'h11);
        cycle(0, 0, 0, 0, 0, 1);
        check("drain2_A", int'(A), 8'h22);
        check("drain2_B", int'(B), 8'h22);
        check("drain2_pend", int'(pend_cnt), 0);

        // flags-only retire
        cycle(1, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        check("flagsonly_A", int'(A), 8'h22);
        check("flagsonly_z", int'(flag_z), 1);
        check("flagsonly_n", int'(flag_n), 0);

        // back-to-back stream into A
        for (int i = 1; i <= 4; i++) begin
            cycle(1, i, 0, 1, 0, 1);
            check("b2b_pend_le1", (pend_cnt <= 1) ? 1 : 0, 1);
        end
        cycle(0, 0, 0, 0, 0, 1);
        check("b2b_final_A", int'(A), 4);

        // reset with two pending writes discards them
        cycle(1, 8'h55, 0, 3, 1, 1);
        cycle(1, 8'h66, 0, 3, 1, 1);
        check("prereset_pend", int'(pend_cnt), 2);
        cycle(1, 8'h77, 0, 3, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        check("postreset_A", int'(A), 0);
        check("postreset_B", int'(B), 0);
        check("postreset_pend", int'(pend_cnt), 0);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 65) ? 1 : 0,
                  int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 35) ? 1 : 0,
                  ($urandom_range(0, 99) < 3) ? 0 : 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
